// File: rtl/pipe_hazard_unit_pkg.sv
// rtl/pipe_hazard_unit_pkg.sv - shared types and constants for the pipeline hazard unit
// Purpose : slot record type, forward-select encoding and legal parameter ranges,
//           shared by pipe_hazard_unit and hazard_slot_match.
// Ports   : none (package)
package pipe_hazard_unit_pkg;

   localparam int PHU_REG_IDX_W = 5;

   // Forward-select value meaning "take the operand from the register file".
   localparam int FWD_RF = 0;

   localparam int DEPTH_MIN       = 2;
   localparam int DEPTH_MAX       = 8;
   localparam int LOAD_LAT_MIN    = 0;
   localparam int FLUSH_DEPTH_MIN = 1;
   localparam int FLUSH_DEPTH_MAX = 4;

   typedef struct packed {
      logic                     valid;
      logic [PHU_REG_IDX_W-1:0] rd;
      logic                     regwrite;
      logic                     is_load;
   } slot_t;

   localparam slot_t SLOT_EMPTY = '0;

   // LOAD_LAT upper bound depends on DEPTH: the load result must be forwardable
   // from some slot no later than WB.
   function automatic logic cfg_legal(input int reg_idx_w, input int depth,
                                      input int load_lat, input int flush_depth);
      return (reg_idx_w == PHU_REG_IDX_W) &&
             (depth >= DEPTH_MIN) && (depth <= DEPTH_MAX) &&
             (load_lat >= LOAD_LAT_MIN) && (load_lat <= depth - 2) &&
             (flush_depth >= FLUSH_DEPTH_MIN) && (flush_depth <= FLUSH_DEPTH_MAX);
   endfunction

endpackage

// File: rtl/pipe_hazard_unit_slot_match.sv
// rtl/pipe_hazard_unit_slot_match.sv - per-slot producer/consumer comparator
// Purpose : decides whether the instruction recorded in one pipeline slot
//           produces a given source register, and whether its result is
//           available for forwarding at that slot position.
// Ports   : rec_i   - slot record {valid, rd, regwrite, is_load}
//           rs_i    - consumer source register index
//           hit_o   - slot is a valid writer of rs_i (rs_i != x0)
//           avail_o - slot result is forwardable at position SLOT_IDX
module hazard_slot_match
   import pipe_hazard_unit_pkg::*;
#(
   parameter int SLOT_IDX = 2,
   parameter int LOAD_LAT = 1
) (
   input  slot_t                    rec_i,
   input  logic [PHU_REG_IDX_W-1:0] rs_i,
   output logic                     hit_o,
   output logic                     avail_o
);

   // x0 is hardwired zero, so it never has a producer.
   assign hit_o   = rec_i.valid & rec_i.regwrite & (rs_i != '0) & (rec_i.rd == rs_i);

   // Load data appears only once the load has moved LOAD_LAT slots past EX.
   assign avail_o = ~rec_i.is_load | (SLOT_IDX > LOAD_LAT + 1);

endmodule

// File: rtl/pipe_hazard_unit.sv
// rtl/pipe_hazard_unit.sv - hazard detection and forwarding control for the in-order pipeline
// Purpose : tracks destination registers of in-flight instructions (slot 1 = EX
//           .. slot DEPTH = WB), selects EX operand forwarding sources, stalls
//           ID on load-use hazards, squashes younger instructions after a taken
//           branch and drives the register-file write enable.
// Ports   : clk, rst                      - clock, synchronous active-high reset
//           id_valid/rs1/rs2/rd           - instruction currently in ID
//           id_regwrite, id_is_load       - ID instruction attributes
//           ex_branch_taken               - EX instruction resolved taken
//           stall, flush                  - hold / kill IF-ID this cycle
//           ex_valid                      - slot 1 holds a real instruction
//           fwd_sel1, fwd_sel2            - 0 = register file, k = slot k result
//           wb_we, wb_rd                  - register-file write port control
module pipe_hazard_unit
   import pipe_hazard_unit_pkg::*;
#(
   parameter int REG_IDX_W   = PHU_REG_IDX_W,
   parameter int DEPTH       = 3,
   parameter int LOAD_LAT    = 1,
   parameter int FLUSH_DEPTH = 2,
   parameter int SEL_W       = $clog2(DEPTH + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 id_valid,
   input  logic [REG_IDX_W-1:0] id_rs1,
   input  logic [REG_IDX_W-1:0] id_rs2,
   input  logic [REG_IDX_W-1:0] id_rd,
   input  logic                 id_regwrite,
   input  logic                 id_is_load,
   input  logic                 ex_branch_taken,
   output logic                 stall,
   output logic                 flush,
   output logic                 ex_valid,
   output logic [SEL_W-1:0]     fwd_sel1,
   output logic [SEL_W-1:0]     fwd_sel2,
   output logic                 wb_we,
   output logic [REG_IDX_W-1:0] wb_rd
);

   localparam int SQ_W = $clog2(FLUSH_DEPTH + 1);

   if (!cfg_legal(REG_IDX_W, DEPTH, LOAD_LAT, FLUSH_DEPTH)) begin : g_cfg_illegal
      $error("pipe_hazard_unit: illegal parameter combination");
   end

   slot_t                slot_q [1:DEPTH];
   slot_t                slot_d [1:DEPTH];
   logic [REG_IDX_W-1:0] ex_rs1_q, ex_rs1_d;
   logic [REG_IDX_W-1:0] ex_rs2_q, ex_rs2_d;
   logic [SQ_W-1:0]      sq_cnt_q, sq_cnt_d;

   logic                 branch_kill;
   logic                 flush_raw;
   logic                 load_use;
   logic                 issue;

   logic [DEPTH:2]       fwd1_hit, fwd1_avail;
   logic [DEPTH:2]       fwd2_hit, fwd2_avail;
   logic [DEPTH-2:0]     lu_hazard;     // bit j-1 covers slot j

   // ---------------------------------------------------------------------
   // Forwarding comparators: slot 1 sources against every older slot.
   // ---------------------------------------------------------------------
   for (genvar k = 2; k <= DEPTH; k++) begin : g_fwd
      hazard_slot_match #(.SLOT_IDX(k), .LOAD_LAT(LOAD_LAT)) u_rs1 (
         .rec_i   (slot_q[k]),
         .rs_i    (ex_rs1_q),
         .hit_o   (fwd1_hit[k]),
         .avail_o (fwd1_avail[k])
      );
      hazard_slot_match #(.SLOT_IDX(k), .LOAD_LAT(LOAD_LAT)) u_rs2 (
         .rec_i   (slot_q[k]),
         .rs_i    (ex_rs2_q),
         .hit_o   (fwd2_hit[k]),
         .avail_o (fwd2_avail[k])
      );
   end

   // ---------------------------------------------------------------------
   // Load-use comparators: ID sources against slots that a consumer issued
   // now would find one position further on. A producer in slot j is seen at
   // slot j+1 when the consumer reaches EX; if it is not available there the
   // consumer must wait. Only slots j <= LOAD_LAT can be too young.
   // ---------------------------------------------------------------------
   for (genvar j = 1; j < DEPTH; j++) begin : g_lu
      if (j <= LOAD_LAT) begin : g_chk
         logic h1, a1, h2, a2;
         hazard_slot_match #(.SLOT_IDX(j + 1), .LOAD_LAT(LOAD_LAT)) u_rs1 (
            .rec_i   (slot_q[j]),
            .rs_i    (id_rs1),
            .hit_o   (h1),
            .avail_o (a1)
         );
         hazard_slot_match #(.SLOT_IDX(j + 1), .LOAD_LAT(LOAD_LAT)) u_rs2 (
            .rec_i   (slot_q[j]),
            .rs_i    (id_rs2),
            .hit_o   (h2),
            .avail_o (a2)
         );
         assign lu_hazard[j-1] = (h1 & ~a1) | (h2 & ~a2);
      end else begin : g_none
         assign lu_hazard[j-1] = 1'b0;
      end
   end

   // ---------------------------------------------------------------------
   // Control outputs. Reset forces every output low regardless of state.
   // ---------------------------------------------------------------------
   assign branch_kill = ex_branch_taken & slot_q[1].valid;
   assign flush_raw   = branch_kill | (sq_cnt_q != '0);
   assign load_use    = id_valid & (|lu_hazard);

   assign flush    = ~rst & flush_raw;
   assign stall    = ~rst & load_use & ~flush_raw;   // a squashed consumer needs no stall
   assign issue    = id_valid & ~stall & ~flush;
   assign ex_valid = ~rst & slot_q[1].valid;

   assign wb_we = ~rst & slot_q[DEPTH].valid & slot_q[DEPTH].regwrite &
                  (slot_q[DEPTH].rd != '0);
   assign wb_rd = rst ? '0 : slot_q[DEPTH].rd;

   // Priority encode: scanning from oldest to youngest lets the youngest
   // available producer overwrite older ones.
   always_comb begin
      fwd_sel1 = SEL_W'(FWD_RF);
      fwd_sel2 = SEL_W'(FWD_RF);
      for (int k = DEPTH; k >= 2; k--) begin
         if (fwd1_hit[k] && fwd1_avail[k]) fwd_sel1 = SEL_W'(k);
         if (fwd2_hit[k] && fwd2_avail[k]) fwd_sel2 = SEL_W'(k);
      end
      if (rst || !slot_q[1].valid) begin
         fwd_sel1 = SEL_W'(FWD_RF);
         fwd_sel2 = SEL_W'(FWD_RF);
      end
   end

   // ---------------------------------------------------------------------
   // Next state: older slots always advance; slot 1 gets ID or a bubble.
   // ---------------------------------------------------------------------
   always_comb begin
      slot_d[1] = SLOT_EMPTY;
      ex_rs1_d  = '0;
      ex_rs2_d  = '0;
      sq_cnt_d  = sq_cnt_q;
      if (issue) begin
         slot_d[1].valid    = 1'b1;
         slot_d[1].rd       = id_rd;
         slot_d[1].regwrite = id_regwrite;
         slot_d[1].is_load  = id_is_load;
         ex_rs1_d           = id_rs1;
         ex_rs2_d           = id_rs2;
      end
      for (int k = 2; k <= DEPTH; k++) begin
         slot_d[k] = slot_q[k-1];
      end
      // The branch cycle itself is one flush cycle, hence FLUSH_DEPTH-1 more.
      if (branch_kill) begin
         sq_cnt_d = SQ_W'(FLUSH_DEPTH - 1);
      end else if (sq_cnt_q != '0) begin
         sq_cnt_d = sq_cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 1; k <= DEPTH; k++) begin
            slot_q[k] <= SLOT_EMPTY;
         end
         ex_rs1_q <= '0;
         ex_rs2_q <= '0;
         sq_cnt_q <= '0;
      end else begin
         for (int k = 1; k <= DEPTH; k++) begin
            slot_q[k] <= slot_d[k];
         end
         ex_rs1_q <= ex_rs1_d;
         ex_rs2_q <= ex_rs2_d;
         sq_cnt_q <= sq_cnt_d;
      end
   end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// tb/tb_pipe_hazard_unit.sv - self-checking bench for pipe_hazard_unit
module tb_pipe_hazard_unit;

   localparam int RW          = 5;
   localparam int DEPTH       = 3;
   localparam int LOAD_LAT    = 1;
   localparam int FLUSH_DEPTH = 2;
   localparam int SEL_W       = $clog2(DEPTH + 1);

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          id_valid = 1'b0;
   logic [RW-1:0] id_rs1 = '0;
   logic [RW-1:0] id_rs2 = '0;
   logic [RW-1:0] id_rd = '0;
   logic          id_regwrite = 1'b0;
   logic          id_is_load = 1'b0;
   logic          ex_branch_taken = 1'b0;
   logic          stall, flush, ex_valid, wb_we;
   logic [SEL_W-1:0] fwd_sel1, fwd_sel2;
   logic [RW-1:0] wb_rd;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   pipe_hazard_unit #(
      .REG_IDX_W(RW), .DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT),
      .FLUSH_DEPTH(FLUSH_DEPTH), .SEL_W(SEL_W)
   ) dut (
      .clk(clk), .rst(rst),
      .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
      .id_regwrite(id_regwrite), .id_is_load(id_is_load),
      .ex_branch_taken(ex_branch_taken),
      .stall(stall), .flush(flush), .ex_valid(ex_valid),
      .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2),
      .wb_we(wb_we), .wb_rd(wb_rd)
   );

   // Reference model: history of what entered EX, indexed by age (0 = in EX now).
   typedef struct packed {
      logic v; logic [RW-1:0] rd; logic rw; logic ld; logic [RW-1:0] rs1; logic [RW-1:0] rs2;
   } ins_t;

   ins_t hist[$];
   int   cyc;
   int   kill_until;
   bit   e_br, e_flush, e_stall, e_ex_valid, e_we;
   int   e_fwd1, e_fwd2, e_wb_rd;

   function automatic bit writes(input ins_t p, input logic [RW-1:0] rs);
      return p.v && p.rw && (rs != 0) && (p.rd == rs);
   endfunction

   task automatic model_reset();
      hist.delete();
      for (int i = 0; i < DEPTH; i++) hist.push_back('0);
      cyc = 0;
      kill_until = 0;
   endtask

   task automatic model_eval();
      ins_t ex, p;
      bit haz;
      ex = hist[0];
      e_ex_valid = ex.v;
      e_br = ex_branch_taken && ex.v;
      e_flush = e_br || (cyc < kill_until);
      haz = 0;
      // A consumer issued now meets producer of age a at age a+1; load data is
      // readable only from age LOAD_LAT+2 onward.
      for (int a = 1; a <= DEPTH; a++) begin
         p = hist[a-1];
         if (id_valid && p.ld && (writes(p, id_rs1) || writes(p, id_rs2)) && (a + 1 < LOAD_LAT + 2))
            haz = 1;
      end
      e_stall = haz && !e_flush;
      e_fwd1 = 0;
      e_fwd2 = 0;
      if (ex.v) begin
         for (int a = 2; a <= DEPTH; a++) begin
            p = hist[a-1];
            if (e_fwd1 == 0 && writes(p, ex.rs1) && (!p.ld || a >= LOAD_LAT + 2)) e_fwd1 = a;
            if (e_fwd2 == 0 && writes(p, ex.rs2) && (!p.ld || a >= LOAD_LAT + 2)) e_fwd2 = a;
         end
      end
      p = hist[DEPTH-1];
      e_we = p.v && p.rw && (p.rd != 0);
      e_wb_rd = int'(p.rd);
      if (rst) begin
         e_br = 0; e_flush = 0; e_stall = 0; e_ex_valid = 0; e_we = 0;
         e_fwd1 = 0; e_fwd2 = 0; e_wb_rd = 0;
      end
   endtask

   task automatic model_step();
      ins_t n;
      if (rst) begin
         model_reset();
      end else begin
         n = '0;
         if (id_valid && !e_stall && !e_flush) begin
            n.v = 1'b1; n.rd = id_rd; n.rw = id_regwrite; n.ld = id_is_load;
            n.rs1 = id_rs1; n.rs2 = id_rs2;
         end
         hist.push_front(n);
         void'(hist.pop_back());
         if (e_br) kill_until = cyc + FLUSH_DEPTH;
         cyc++;
      end
   endtask

   task automatic drive(input bit v, input int rd, input int rs1, input int rs2,
                        input bit rw, input bit ld, input bit br);
      id_valid = v; id_rd = RW'(rd); id_rs1 = RW'(rs1); id_rs2 = RW'(rs2);
      id_regwrite = rw; id_is_load = ld; ex_branch_taken = br;
   endtask

   task automatic nop();
      drive(0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      nop();
      adv();
      adv();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive(1, 3, 3, 3, 1, 1, 1);
      adv(); adv(); settle();
      n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL rst_stall: got %b want 0", stall); end
      n_checks++; if (flush !== 1'b0) begin n_errors++; $display("FAIL rst_flush: got %b want 0", flush); end
      n_checks++; if (ex_valid !== 1'b0) begin n_errors++; $display("FAIL rst_ex_valid: got %b want 0", ex_valid); end
      n_checks++; if (fwd_sel1 !== '0) begin n_errors++; $display("FAIL rst_fwd1: got %0d want 0", fwd_sel1); end
      n_checks++; if (fwd_sel2 !== '0) begin n_errors++; $display("FAIL rst_fwd2: got %0d want 0", fwd_sel2); end
      n_checks++; if (wb_we !== 1'b0) begin n_errors++; $display("FAIL rst_wb_we: got %b want 0", wb_we); end
      n_checks++; if (wb_rd !== '0) begin n_errors++; $display("FAIL rst_wb_rd: got %0d want 0", wb_rd); end
      rst = 1'b0;
      nop();
      adv(); settle();
      n_checks++; if (ex_valid !== 1'b0) begin n_errors++; $display("FAIL rst_post_ex_valid: got %b want 0", ex_valid); end
      n_checks++; if (flush !== 1'b0) begin n_errors++; $display("FAIL rst_post_flush: got %b want 0", flush); end
      adv();
   endtask

   task automatic test_independent();
      do_reset();
      for (int c = 0; c < 8; c++) begin
         if (c < 4) drive(1, c + 1, 0, 0, 1, 0, 0); else nop();
         settle();
         n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL indep_stall c=%0d: got %b want 0", c, stall); end
         n_checks++; if (flush !== 1'b0) begin n_errors++; $display("FAIL indep_flush c=%0d: got %b want 0", c, flush); end
         n_checks++; if (fwd_sel1 !== '0 || fwd_sel2 !== '0) begin n_errors++; $display("FAIL indep_fwd c=%0d: got %0d/%0d want 0/0", c, fwd_sel1, fwd_sel2); end
         n_checks++; if (ex_valid !== (c >= 1 && c <= 4)) begin n_errors++; $display("FAIL indep_ex_valid c=%0d: got %b want %b", c, ex_valid, (c >= 1 && c <= 4)); end
         n_checks++; if (wb_we !== (c >= 3 && c <= 6)) begin n_errors++; $display("FAIL indep_wb_we c=%0d: got %b want %b", c, wb_we, (c >= 3 && c <= 6)); end
         if (c >= 3 && c <= 6) begin
            n_checks++; if (wb_rd !== RW'(c - 2)) begin n_errors++; $display("FAIL indep_wb_rd c=%0d: got %0d want %0d", c, wb_rd, c - 2); end
         end
         adv();
      end
   endtask

   task automatic test_forward();
      do_reset();
      drive(1, 5, 0, 0, 1, 0, 0); settle(); adv();
      drive(1, 6, 5, 5, 1, 0, 0); settle();
      n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL fwd_adj_stall: got %b want 0", stall); end
      adv();
      nop(); settle();
      n_checks++; if (fwd_sel1 !== SEL_W'(2)) begin n_errors++; $display("FAIL fwd_adj_sel1: got %0d want 2", fwd_sel1); end
      n_checks++; if (fwd_sel2 !== SEL_W'(2)) begin n_errors++; $display("FAIL fwd_adj_sel2: got %0d want 2", fwd_sel2); end
      adv();
      do_reset();
      drive(1, 5, 0, 0, 1, 0, 0); settle(); adv();
      nop(); settle(); adv();
      drive(1, 6, 5, 5, 1, 0, 0); settle();
      n_checks++; if (fwd_sel1 !== '0) begin n_errors++; $display("FAIL fwd_bubble_ex: got %0d want 0", fwd_sel1); end
      adv();
      nop(); settle();
      n_checks++; if (fwd_sel1 !== SEL_W'(3)) begin n_errors++; $display("FAIL fwd_gap_sel1: got %0d want 3", fwd_sel1); end
      n_checks++; if (fwd_sel2 !== SEL_W'(3)) begin n_errors++; $display("FAIL fwd_gap_sel2: got %0d want 3", fwd_sel2); end
      adv();
   endtask

   task automatic test_load_use();
      do_reset();
      drive(1, 7, 0, 0, 1, 1, 0); settle();
      n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL lu_c0_stall: got %b want 0", stall); end
      adv();
      drive(1, 8, 7, 0, 1, 0, 0); settle();
      n_checks++; if (stall !== 1'b1) begin n_errors++; $display("FAIL lu_c1_stall: got %b want 1", stall); end
      adv();
      drive(1, 8, 7, 0, 1, 0, 0); settle();
      n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL lu_c2_stall: got %b want 0", stall); end
      n_checks++; if (ex_valid !== 1'b0) begin n_errors++; $display("FAIL lu_c2_bubble: got %b want 0", ex_valid); end
      adv();
      nop(); settle();
      n_checks++; if (ex_valid !== 1'b1) begin n_errors++; $display("FAIL lu_c3_ex_valid: got %b want 1", ex_valid); end
      n_checks++; if (fwd_sel1 !== SEL_W'(3)) begin n_errors++; $display("FAIL lu_c3_fwd1: got %0d want 3", fwd_sel1); end
      n_checks++; if (fwd_sel2 !== '0) begin n_errors++; $display("FAIL lu_c3_fwd2: got %0d want 0", fwd_sel2); end
      adv();
   endtask

   task automatic test_branch();
      do_reset();
      drive(1, 9, 0, 0, 0, 0, 0); settle(); adv();
      drive(1, 10, 0, 0, 1, 0, 1); settle();
      n_checks++; if (flush !== 1'b1) begin n_errors++; $display("FAIL br_c1_flush: got %b want 1", flush); end
      adv();
      drive(1, 11, 0, 0, 1, 0, 0); settle();
      n_checks++; if (flush !== 1'b1) begin n_errors++; $display("FAIL br_c2_flush: got %b want 1", flush); end
      n_checks++; if (ex_valid !== 1'b0) begin n_errors++; $display("FAIL br_c2_ex_valid: got %b want 0", ex_valid); end
      adv();
      drive(1, 12, 0, 0, 1, 0, 0); settle();
      n_checks++; if (flush !== 1'b0) begin n_errors++; $display("FAIL br_c3_flush: got %b want 0", flush); end
      n_checks++; if (ex_valid !== 1'b0) begin n_errors++; $display("FAIL br_c3_ex_valid: got %b want 0", ex_valid); end
      adv();
      for (int c = 4; c < 9; c++) begin
         nop(); settle();
         n_checks++; if (ex_valid !== (c == 4)) begin n_errors++; $display("FAIL br_ex_valid c=%0d: got %b want %b", c, ex_valid, (c == 4)); end
         n_checks++; if (wb_we !== (c == 6)) begin n_errors++; $display("FAIL br_wb_we c=%0d: got %b want %b", c, wb_we, (c == 6)); end
         if (c == 6) begin
            n_checks++; if (wb_rd !== RW'(12)) begin n_errors++; $display("FAIL br_wb_rd: got %0d want 12", wb_rd); end
         end
         adv();
      end
   endtask

   task automatic test_stall_vs_branch();
      do_reset();
      drive(1, 7, 0, 0, 1, 1, 0); settle(); adv();
      drive(1, 8, 7, 0, 1, 0, 1); settle();
      n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL svb_stall: got %b want 0", stall); end
      n_checks++; if (flush !== 1'b1) begin n_errors++; $display("FAIL svb_flush: got %b want 1", flush); end
      adv();
      nop(); settle();
      n_checks++; if (ex_valid !== 1'b0) begin n_errors++; $display("FAIL svb_c2_ex_valid: got %b want 0", ex_valid); end
      adv();
      nop(); settle();
      n_checks++; if (ex_valid !== 1'b0) begin n_errors++; $display("FAIL svb_c3_ex_valid: got %b want 0", ex_valid); end
      n_checks++; if (flush !== 1'b0) begin n_errors++; $display("FAIL svb_c3_flush: got %b want 0", flush); end
      adv();
   endtask

   task automatic test_x0();
      do_reset();
      drive(1, 0, 0, 0, 1, 0, 0); settle(); adv();
      drive(1, 0, 0, 0, 1, 1, 0); settle(); adv();
      drive(1, 2, 0, 0, 1, 0, 0); settle();
      n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL x0_stall: got %b want 0", stall); end
      adv();
      nop(); settle();
      n_checks++; if (fwd_sel1 !== '0 || fwd_sel2 !== '0) begin n_errors++; $display("FAIL x0_fwd: got %0d/%0d want 0/0", fwd_sel1, fwd_sel2); end
      n_checks++; if (wb_we !== 1'b0) begin n_errors++; $display("FAIL x0_wb_alu: got %b want 0", wb_we); end
      adv();
      nop(); settle();
      n_checks++; if (wb_we !== 1'b0) begin n_errors++; $display("FAIL x0_wb_load: got %b want 0", wb_we); end
      adv();
      nop(); settle();
      n_checks++; if (wb_we !== 1'b1 || wb_rd !== RW'(2)) begin n_errors++; $display("FAIL x0_wb_x2: got we=%b rd=%0d want we=1 rd=2", wb_we, wb_rd); end
      adv();
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int c = 0; c < 3; c++) begin
         drive(1, c + 1, 0, 0, 1, 0, 0); settle(); adv();
      end
      drive(0, 0, 0, 0, 0, 0, 1);
      rst = 1'b1;
      settle();
      n_checks++; if (ex_valid !== 1'b0 || wb_we !== 1'b0 || flush !== 1'b0) begin n_errors++; $display("FAIL midrst_during: got ev=%b we=%b fl=%b want 0/0/0", ex_valid, wb_we, flush); end
      adv();
      rst = 1'b0;
      nop(); settle();
      n_checks++; if (ex_valid !== 1'b0) begin n_errors++; $display("FAIL midrst_ex_valid: got %b want 0", ex_valid); end
      n_checks++; if (wb_we !== 1'b0) begin n_errors++; $display("FAIL midrst_wb_we: got %b want 0", wb_we); end
      n_checks++; if (flush !== 1'b0) begin n_errors++; $display("FAIL midrst_flush: got %b want 0", flush); end
      adv();
      settle();
      n_checks++; if (wb_we !== 1'b0 || flush !== 1'b0) begin n_errors++; $display("FAIL midrst_next: got we=%b fl=%b want 0/0", wb_we, flush); end
      adv();
   endtask

   task automatic test_random();
      do_reset();
      model_reset();
      for (int n = 0; n < 3000; n++) begin
         rst             = ($urandom_range(0, 99) == 0);
         id_valid        = ($urandom_range(0, 9) < 8);
         id_rd           = RW'($urandom_range(0, 7));
         id_rs1          = RW'($urandom_range(0, 7));
         id_rs2          = RW'($urandom_range(0, 7));
         id_regwrite     = ($urandom_range(0, 9) < 7);
         id_is_load      = ($urandom_range(0, 9) < 3);
         ex_branch_taken = ($urandom_range(0, 9) == 0);
         model_eval();
         settle();
         n_checks++; if (stall !== e_stall) begin n_errors++; $display("FAIL rnd_stall n=%0d: got %b want %b", n, stall, e_stall); end
         n_checks++; if (flush !== e_flush) begin n_errors++; $display("FAIL rnd_flush n=%0d: got %b want %b", n, flush, e_flush); end
         n_checks++; if (ex_valid !== e_ex_valid) begin n_errors++; $display("FAIL rnd_ex_valid n=%0d: got %b want %b", n, ex_valid, e_ex_valid); end
         n_checks++; if (fwd_sel1 !== SEL_W'(e_fwd1)) begin n_errors++; $display("FAIL rnd_fwd1 n=%0d: got %0d want %0d", n, fwd_sel1, e_fwd1); end
         n_checks++; if (fwd_sel2 !== SEL_W'(e_fwd2)) begin n_errors++; $display("FAIL rnd_fwd2 n=%0d: got %0d want %0d", n, fwd_sel2, e_fwd2); end
         n_checks++; if (wb_we !== e_we) begin n_errors++; $display("FAIL rnd_wb_we n=%0d: got %b want %b", n, wb_we, e_we); end
         if (e_we) begin
            n_checks++; if (wb_rd !== RW'(e_wb_rd)) begin n_errors++; $display("FAIL rnd_wb_rd n=%0d: got %0d want %0d", n, wb_rd, e_wb_rd); end
         end
         model_step();
         adv();
      end
      rst = 1'b0;
      nop();
   endtask

   initial begin
      test_reset();
      test_independent();
      test_forward();
      test_load_use();
      test_branch();
      test_stall_vs_branch();
      test_x0();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got no finish by time limit, want finish");
      $fatal(1);
   end

endmodule
